// File: rtl/vortex_axil_ctrl_master_pkg.sv
// Shared types and constants for the Vortex AXI4-Lite control master.
// Holds the FSM state encoding, AXI response codes and default widths.
package vortex_axil_ctrl_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WRESP = 3'd2,
        ST_RD    = 3'd3,
        ST_RDATA = 3'd4,
        ST_RESP  = 3'd5
    } ctrl_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'd1;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

    localparam int DEF_ADDR_WIDTH     = 8;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/vortex_axil_ctrl_master_if.sv
// AXI4-Lite control channel bundle (AW/W/B and AR/R) between the master and the Vortex slave.
interface vortex_axil_ctrl_master_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/vortex_axil_timeout_cnt.sv
// Saturating phase-wait counter; reached flags that the LIMIT-th cycle of a phase is next,
// so a flag registered from it becomes visible exactly in that cycle.
module vortex_axil_timeout_cnt #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic reached
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_ahead;

    // cnt holds the phase cycles already completed; +2 looks past the current cycle and the flag register
    assign cnt_ahead = {1'b0, cnt} + (CW+1)'(2);
    assign reached   = en && (cnt_ahead >= (CW+1)'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vortex_axil_ctrl_master.sv
// Single-outstanding AXI4-Lite control master for the Vortex control slave.
// state    | meaning
// ST_IDLE  | req_ready high, waiting for a request
// ST_WR    | AW and W offered, each dropped on its own handshake
// ST_WRESP | bready high, waiting for B
// ST_RD    | AR offered until arready
// ST_RDATA | rready high, waiting for R
// ST_RESP  | rsp_valid pulse, back to idle
module vortex_axil_ctrl_master
    import vortex_axil_ctrl_master_pkg::*;
#(
    parameter int VORTEX_AXI_CTRL_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int VORTEX_AXI_CTRL_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES             = DEF_TIMEOUT_CYCLES
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic                                    req_we,
    input  logic [VORTEX_AXI_CTRL_ADDR_WIDTH-1:0]   req_addr,
    input  logic [VORTEX_AXI_CTRL_DATA_WIDTH-1:0]   req_wdata,
    input  logic [VORTEX_AXI_CTRL_DATA_WIDTH/8-1:0] req_wstrb,
    output logic                                    rsp_valid,
    output logic [VORTEX_AXI_CTRL_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                              rsp_resp,
    output logic                                    timeout_o,
    vortex_axil_ctrl_master_if.master               m_axi_ctrl
);

    ctrl_state_e state;
    logic        aw_done;
    logic        w_done;
    logic        accept;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        wr_done_now;
    logic        tmo_clear;
    logic        tmo_en;
    logic        tmo_reached;

    assign accept      = req_valid && req_ready;
    assign aw_hs       = m_axi_ctrl.awvalid && m_axi_ctrl.awready;
    assign w_hs        = m_axi_ctrl.wvalid && m_axi_ctrl.wready;
    assign ar_hs       = m_axi_ctrl.arvalid && m_axi_ctrl.arready;
    assign wr_done_now = (aw_done || aw_hs) && (w_done || w_hs);

    // Counter restarts whenever a new wait phase begins
    assign tmo_clear = accept
                     || ((state == ST_WR) && wr_done_now)
                     || ((state == ST_RD) && ar_hs);
    assign tmo_en    = ((state == ST_WR) || (state == ST_WRESP) ||
                        (state == ST_RD) || (state == ST_RDATA)) && !tmo_clear;

    vortex_axil_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear),
        .en      (tmo_en),
        .reached (tmo_reached)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            req_ready          <= 1'b1;
            aw_done            <= 1'b0;
            w_done             <= 1'b0;
            m_axi_ctrl.awvalid <= 1'b0;
            m_axi_ctrl.awaddr  <= '0;
            m_axi_ctrl.wvalid  <= 1'b0;
            m_axi_ctrl.wdata   <= '0;
            m_axi_ctrl.wstrb   <= '0;
            m_axi_ctrl.bready  <= 1'b0;
            m_axi_ctrl.arvalid <= 1'b0;
            m_axi_ctrl.araddr  <= '0;
            m_axi_ctrl.rready  <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= '0;
            rsp_resp           <= AXI_RESP_OKAY;
            timeout_o          <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            // Sticky: valid is never withdrawn, the transaction just keeps waiting
            if (tmo_reached) begin
                timeout_o <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        timeout_o <= 1'b0;
                        if (req_we) begin
                            state              <= ST_WR;
                            aw_done            <= 1'b0;
                            w_done             <= 1'b0;
                            m_axi_ctrl.awvalid <= 1'b1;
                            m_axi_ctrl.awaddr  <= req_addr;
                            m_axi_ctrl.wvalid  <= 1'b1;
                            m_axi_ctrl.wdata   <= req_wdata;
                            m_axi_ctrl.wstrb   <= req_wstrb;
                        end else begin
                            state              <= ST_RD;
                            m_axi_ctrl.arvalid <= 1'b1;
                            m_axi_ctrl.araddr  <= req_addr;
                        end
                    end
                end

                ST_WR: begin
                    if (aw_hs) begin
                        m_axi_ctrl.awvalid <= 1'b0;
                        aw_done            <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_ctrl.wvalid <= 1'b0;
                        w_done            <= 1'b1;
                    end
                    if (wr_done_now) begin
                        state             <= ST_WRESP;
                        m_axi_ctrl.bready <= 1'b1;
                    end
                end

                ST_WRESP: begin
                    if (m_axi_ctrl.bvalid) begin
                        state             <= ST_RESP;
                        m_axi_ctrl.bready <= 1'b0;
                        rsp_valid         <= 1'b1;
                        rsp_rdata         <= '0;
                        rsp_resp          <= m_axi_ctrl.bresp;
                    end
                end

                ST_RD: begin
                    if (ar_hs) begin
                        state              <= ST_RDATA;
                        m_axi_ctrl.arvalid <= 1'b0;
                        m_axi_ctrl.rready  <= 1'b1;
                    end
                end

                ST_RDATA: begin
                    if (m_axi_ctrl.rvalid) begin
                        state             <= ST_RESP;
                        m_axi_ctrl.rready <= 1'b0;
                        rsp_valid         <= 1'b1;
                        rsp_rdata         <= m_axi_ctrl.rdata;
                        rsp_resp          <= m_axi_ctrl.rresp;
                    end
                end

                ST_RESP: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
